// File: rtl/k_and_s_pkg.sv
// Shared definitions for the K&S datapath family.
// Holds the 8-bit opcode values, the decoded instruction type driven out to
// the control unit, and the ALU operation encodings used on the operation port.
package k_and_s_pkg;

    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNEG   = 8'h03;
    localparam logic [7:0] OPC_BOV    = 8'h04;
    localparam logic [7:0] OPC_BNOV   = 8'h05;
    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_BRANCH = 4'd1,
        I_BZERO  = 4'd2,
        I_BNEG   = 4'd3,
        I_BOV    = 4'd4,
        I_BNOV   = 4'd5,
        I_LOAD   = 4'd6,
        I_STORE  = 4'd7,
        I_MOVE   = 4'd8,
        I_ADD    = 4'd9,
        I_SUB    = 4'd10,
        I_AND    = 4'd11,
        I_OR     = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_OR  = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

endpackage

// File: rtl/dp_reg_file.sv
// General register file: NREGS x DATA_W, two combinational read ports and one
// synchronous write port. All registers clear on asynchronous active-low reset.
// A read of the register being written in the same cycle returns the old value.
// Ports: clk, rst_n, rd_a_addr/rd_a_data, rd_b_addr/rd_b_data,
//        wr_en, wr_addr, wr_data.
module dp_reg_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(NREGS)-1:0]   rd_a_addr,
    input  logic [$clog2(NREGS)-1:0]   rd_b_addr,
    input  logic                       wr_en,
    input  logic [$clog2(NREGS)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_a_data,
    output logic [DATA_W-1:0]          rd_b_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_data = regs_q[rd_a_addr];
    assign rd_b_data = regs_q[rd_b_addr];

endmodule

// File: rtl/data_path_param.sv
// Parametrised K&S datapath: IR, PC, instruction decoder, register file,
// ALU (ADD/AND/OR/SUB) and registered flags. Driven by the K&S control unit
// strobes/selects, talks to a single-port program/data RAM.
// Ports: clk, rst_n (async active-low); control inputs branch, pc_enable,
//        ir_enable, addr_sel, c_sel, operation, write_reg_enable,
//        flags_reg_enable; status outputs decoded_instruction, zero_op,
//        neg_op, unsigned_overflow, signed_overflow; RAM side ram_addr,
//        data_out (bus A), data_in.
module data_path_param
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4,
    parameter int RS_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              uov_q, uov_d;
    logic              sov_q, sov_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] mem_addr;
    logic [RS_W-1:0]   ra, rb, rc, rm;
    logic [RS_W-1:0]   a_addr, b_addr, c_addr;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum_ext;
    logic              alu_uov, alu_sov;
    logic              ir_unused;

    // Instruction fields
    always_comb begin
        opcode    = ir_q[DATA_W-1 -: 8];
        mem_addr  = ir_q[ADDR_W-1:0];
        rb        = ir_q[RS_W-1:0];
        ra        = ir_q[2*RS_W-1:RS_W];
        rc        = ir_q[3*RS_W-1:2*RS_W];
        rm        = ir_q[ADDR_W+RS_W-1:ADDR_W];
        // Some IR bits carry no field at certain parameter choices.
        ir_unused = ^ir_q;
    end

    // Decoder
    always_comb begin
        decoded_instruction = I_NOP;
        case (opcode)
            OPC_BRANCH: decoded_instruction = I_BRANCH;
            OPC_BZERO:  decoded_instruction = I_BZERO;
            OPC_BNEG:   decoded_instruction = I_BNEG;
            OPC_BOV:    decoded_instruction = I_BOV;
            OPC_BNOV:   decoded_instruction = I_BNOV;
            OPC_LOAD:   decoded_instruction = I_LOAD;
            OPC_STORE:  decoded_instruction = I_STORE;
            OPC_MOVE:   decoded_instruction = I_MOVE;
            OPC_ADD:    decoded_instruction = I_ADD;
            OPC_SUB:    decoded_instruction = I_SUB;
            OPC_AND:    decoded_instruction = I_AND;
            OPC_OR:     decoded_instruction = I_OR;
            OPC_HALT:   decoded_instruction = I_HALT;
            default:    decoded_instruction = I_NOP;
        endcase
    end

    // Register addressing; MOVE reads ra on both buses so OR passes A through.
    always_comb begin
        a_addr = ra;
        b_addr = rb;
        c_addr = rc;
        case (decoded_instruction)
            I_LOAD:  c_addr = rm;
            I_STORE: a_addr = rm;
            I_MOVE:  b_addr = ra;
            default: ;
        endcase
    end

    dp_reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (a_addr),
        .rd_b_addr (b_addr),
        .wr_en     (write_reg_enable),
        .wr_addr   (c_addr),
        .wr_data   (bus_c),
        .rd_a_data (bus_a),
        .rd_b_data (bus_b)
    );

    // ALU
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (alu_op_t'(operation))
            ALU_ADD: begin
                sum_ext = {1'b0, bus_a} + {1'b0, bus_b};
                alu_res = sum_ext[DATA_W-1:0];
                alu_uov = sum_ext[DATA_W];
                // carry into MSB recovered from the MSB sum bit
                alu_sov = (alu_res[DATA_W-1] ^ bus_a[DATA_W-1] ^ bus_b[DATA_W-1])
                          ^ sum_ext[DATA_W];
            end
            ALU_SUB: begin
                sum_ext = {1'b0, bus_a} + {1'b0, ~bus_b} + (DATA_W+1)'(1);
                alu_res = sum_ext[DATA_W-1:0];
                // no carry out of A + ~B + 1 means a borrow occurred
                alu_uov = ~sum_ext[DATA_W];
                alu_sov = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != bus_a[DATA_W-1]);
            end
            ALU_AND: alu_res = bus_a & bus_b;
            ALU_OR:  alu_res = bus_a | bus_b;
            default: ;
        endcase
    end

    // Next-state for IR, PC and flags
    always_comb begin
        bus_c = c_sel ? alu_res : data_in;

        ir_d = ir_q;
        if (ir_enable) begin
            ir_d = data_in;
        end

        pc_d = pc_q;
        if (pc_enable) begin
            pc_d = branch ? mem_addr : pc_q + ADDR_W'(1);
        end

        zero_d = zero_q;
        neg_d  = neg_q;
        uov_d  = uov_q;
        sov_d  = sov_q;
        if (flags_reg_enable) begin
            zero_d = (alu_res == '0);
            neg_d  = alu_res[DATA_W-1];
            uov_d  = alu_uov;
            sov_d  = alu_sov;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= '0;
            pc_q   <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            pc_q   <= pc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            uov_q  <= uov_d;
            sov_q  <= sov_d;
        end
    end

    assign ram_addr          = addr_sel ? pc_q : mem_addr;
    assign data_out          = bus_a;
    assign zero_op           = zero_q;
    assign neg_op            = neg_q;
    assign unsigned_overflow = uov_q;
    assign signed_overflow   = sov_q;

endmodule

// File: tb/tb_data_path_param.sv
// Self-checking bench for data_path_param at DATA_W=16, ADDR_W=5, NREGS=4.
// Directed scenarios followed by randomized control/data, all checked against
// an arithmetic reference model of IR, PC, registers and flags.
module tb_data_path_param;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out, data_in;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int unsigned m_regs [4];
    int unsigned m_pc, m_ir;
    bit          m_z, m_n, m_u, m_s;

    logic [7:0] opc_tab [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h81,
                                 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};

    data_path_param #(.DATA_W(16), .ADDR_W(5), .NREGS(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic decoded_instruction_type exp_dec(int unsigned ir);
        case ((ir >> 8) & 8'hFF)
            8'h01: return I_BRANCH;
            8'h02: return I_BZERO;
            8'h03: return I_BNEG;
            8'h04: return I_BOV;
            8'h05: return I_BNOV;
            8'h81: return I_LOAD;
            8'h82: return I_STORE;
            8'h91: return I_MOVE;
            8'hA1: return I_ADD;
            8'hA2: return I_SUB;
            8'hA3: return I_AND;
            8'hA4: return I_OR;
            8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    function automatic int unsigned sel_a(int unsigned ir);
        int unsigned op = (ir >> 8) & 8'hFF;
        return (op == 8'h82) ? ((ir >> 5) & 3) : ((ir >> 2) & 3);
    endfunction
    function automatic int unsigned sel_b(int unsigned ir);
        int unsigned op = (ir >> 8) & 8'hFF;
        return (op == 8'h91) ? ((ir >> 2) & 3) : (ir & 3);
    endfunction
    function automatic int unsigned sel_c(int unsigned ir);
        int unsigned op = (ir >> 8) & 8'hFF;
        return (op == 8'h81) ? ((ir >> 5) & 3) : ((ir >> 4) & 3);
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_pc = 0; m_ir = 0;
        m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    endtask

    task automatic check_all();
        int unsigned exp_addr = addr_sel ? m_pc : (m_ir & 31);
        check("ram_addr", 32'(ram_addr), exp_addr);
        check("data_out", 32'(data_out), m_regs[sel_a(m_ir)]);
        check("decode", 32'(decoded_instruction), 32'(exp_dec(m_ir)));
        check("zero", 32'(zero_op), 32'(m_z));
        check("neg", 32'(neg_op), 32'(m_n));
        check("uov", 32'(unsigned_overflow), 32'(m_u));
        check("sov", 32'(signed_overflow), 32'(m_s));
    endtask

    // One clock: model computes from inputs held before the edge.
    task automatic cyc();
        int unsigned a, b, res, full;
        int          sa, sb, sr;
        bit          u, s;
        logic signed [15:0] ta, tb;
        a = m_regs[sel_a(m_ir)];
        b = m_regs[sel_b(m_ir)];
        ta = a[15:0]; tb = b[15:0];
        sa = ta; sb = tb;
        u = 0; s = 0;
        case (operation)
            2'b00: begin
                full = a + b; res = full % 65536; u = (full > 65535);
                sr = sa + sb; s = (sr > 32767) || (sr < -32768);
            end
            2'b11: begin
                res = (a + 65536 - b) % 65536; u = (a < b);
                sr = sa - sb; s = (sr > 32767) || (sr < -32768);
            end
            2'b01: res = a & b;
            default: res = a | b;
        endcase
        @(posedge clk);
        #1;
        if (write_reg_enable) m_regs[sel_c(m_ir)] = c_sel ? res : 32'(data_in);
        if (pc_enable) m_pc = branch ? (m_ir & 31) : (m_pc + 1) % 32;
        if (flags_reg_enable) begin
            m_z = (res == 0); m_n = (res >= 32768); m_u = u; m_s = s;
        end
        if (ir_enable) m_ir = 32'(data_in);
        check_all();
    endtask

    task automatic load_ir(input logic [15:0] v);
        data_in = v; ir_enable = 1'b1;
        cyc();
        ir_enable = 1'b0;
    endtask

    task automatic set_reg(input int unsigned k, input logic [15:0] v);
        load_ir(16'h8100 | 16'(k << 5));
        data_in = v; c_sel = 1'b0; write_reg_enable = 1'b1;
        cyc();
        write_reg_enable = 1'b0;
    endtask

    task automatic alu_op(input logic [15:0] instr, input logic [1:0] op, input logic fl_en);
        load_ir(instr);
        operation = op; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = fl_en;
        cyc();
        write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 1;
        c_sel = 0; operation = 2'b00; write_reg_enable = 0; flags_reg_enable = 0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_decode_nop", 32'(decoded_instruction), 32'(I_NOP));
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap and branch target
        load_ir(16'h011F);
        pc_enable = 1; branch = 1; cyc();
        check("pc_branch31", 32'(ram_addr), 32'd31);
        branch = 0; cyc();
        check("pc_wrap", 32'(ram_addr), 32'd0);
        pc_enable = 0;
        load_ir(16'h0113);
        pc_enable = 1; branch = 1; cyc();
        check("pc_branch19", 32'(ram_addr), 32'd19);
        pc_enable = 0; branch = 0;

        // ADD signed overflow
        set_reg(1, 16'h7FFF);
        set_reg(2, 16'h0001);
        alu_op(16'hA136, 2'b00, 1'b1);
        check("add_neg", 32'(neg_op), 32'd1);
        check("add_sov", 32'(signed_overflow), 32'd1);
        check("add_uov", 32'(unsigned_overflow), 32'd0);
        check("add_zero", 32'(zero_op), 32'd0);
        load_ir(16'h8260);
        check("add_r3", 32'(data_out), 32'h8000);

        // SUB borrow, then equal operands
        set_reg(1, 16'h0003);
        set_reg(2, 16'h0005);
        alu_op(16'hA236, 2'b11, 1'b1);
        check("sub_uov", 32'(unsigned_overflow), 32'd1);
        check("sub_sov", 32'(signed_overflow), 32'd0);
        check("sub_neg", 32'(neg_op), 32'd1);
        load_ir(16'h8260);
        check("sub_r3", 32'(data_out), 32'hFFFE);
        set_reg(1, 16'h0005);
        alu_op(16'hA236, 2'b11, 1'b1);
        check("sub_eq_zero", 32'(zero_op), 32'd1);
        check("sub_eq_uov", 32'(unsigned_overflow), 32'd0);

        // Flag hold: clear zero, then a zero result with flags disabled
        alu_op(16'hA136, 2'b00, 1'b1);
        check("hold_pre_zero", 32'(zero_op), 32'd0);
        alu_op(16'hA236, 2'b11, 1'b0);
        check("hold_zero", 32'(zero_op), 32'd0);

        // LOAD/STORE
        load_ir(16'h8125);
        addr_sel = 0; #1;
        check("load_addr", 32'(ram_addr), 32'd5);
        data_in = 16'hBEEF; c_sel = 0; write_reg_enable = 1; cyc();
        write_reg_enable = 0;
        load_ir(16'h8225);
        check("store_data", 32'(data_out), 32'hBEEF);
        addr_sel = 1;

        // Same-cycle write/read of r2 returns old value
        load_ir(16'hA12A);
        data_in = 16'h1234; c_sel = 0; write_reg_enable = 1; #1;
        check("hazard_old", 32'(data_out), 32'h0005);
        cyc();
        write_reg_enable = 0;
        check("hazard_new", 32'(data_out), 32'h1234);

        // Unknown opcode
        load_ir(16'h5500);
        check("opc55_nop", 32'(decoded_instruction), 32'(I_NOP));

        // Mid-cycle reset with pc_enable active
        load_ir(16'hA136);
        pc_enable = 1; cyc(); cyc();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("midrst_pc", 32'(ram_addr), 32'd0);
        check("midrst_dec", 32'(decoded_instruction), 32'(I_NOP));
        @(negedge clk);
        rst_n = 1'b1;
        pc_enable = 0;

        // Randomized phase
        for (int i = 0; i < 300; i++) begin
            branch           = 1'($urandom);
            pc_enable        = 1'($urandom);
            ir_enable        = ($urandom_range(0, 3) == 0);
            addr_sel         = 1'($urandom);
            c_sel            = 1'($urandom);
            operation        = 2'($urandom);
            write_reg_enable = 1'($urandom);
            flags_reg_enable = 1'($urandom);
            if ($urandom_range(0, 1) == 0)
                data_in = {opc_tab[$urandom_range(0, 13)], 8'($urandom)};
            else
                data_in = 16'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_path_param.md
Name: data_path_param

Overview:
- Parametrised next-generation datapath for the K&S processor.
- Generalises data width, address width and register count.
- Adds what the fixed 16-bit datapath lacks: a real register file, an instruction decoder, a full SUB ALU op, registered flags, and defined reset of all state.
- Sits between the K&S control unit (drives the enables and selects) and the single-port program/data RAM.

Parameters:
- DATA_W, 16: datapath and instruction width; must be at least 8 + max(3*RS_W, ADDR_W+RS_W).
- ADDR_W, 5: RAM address and PC width.
- NREGS, 4: number of general registers; power of 2 and at least 2.
- RS_W, $clog2(NREGS): register-select width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch  in  1  PC loads instruction address field instead of incrementing.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR load strobe.
- addr_sel  in  1  1: ram_addr=PC; 0: ram_addr=instruction address field.
- c_sel  in  1  1: register write data = ALU result; 0: register write data = data_in.
- operation  in  2  00 ADD, 01 AND, 10 OR, 11 SUB (A-B).
- write_reg_enable  in  1  register file write strobe.
- flags_reg_enable  in  1  flag register load strobe.
- decoded_instruction  out  enum  decoded_instruction_type from the IR.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  store data, equal to bus A.
- data_in  in  DATA_W  RAM read data.

Behaviour:
- Reset: IR, PC, all registers and all four flags clear to 0 asynchronously. decoded_instruction is then I_NOP.
- Instruction fields:
  - opcode = IR[DATA_W-1 -: 8]
  - mem_addr = IR[ADDR_W-1:0]
  - rb = IR[RS_W-1:0], ra = IR[2RS_W-1:RS_W], rc = IR[3RS_W-1:2RS_W]
  - rm = IR[ADDR_W+RS_W-1:ADDR_W]
- Opcodes: NOP 00, BRANCH 01, BZERO 02, BNEG 03, BOV 04, BNOV 05, LOAD 81, STORE 82, MOVE 91, ADD A1, SUB A2, AND A3, OR A4, HALT FF. Any other value decodes to I_NOP.
- Register addressing by opcode:
  - LOAD: c=rm.
  - STORE: a=rm.
  - MOVE: c=rc, a=ra, b=ra (so OR passes A through).
  - ALU ops: c=rc, a=ra, b=rb.
- IR: loads data_in on the clk edge where ir_enable=1. Decode is combinational from the IR, so it is valid in the cycle after the load.
- PC: updates only when pc_enable=1.
  - branch=1: PC <= mem_addr.
  - otherwise: PC <= PC+1, wrapping 2^ADDR_W-1 -> 0.
- ram_addr: combinational, addr_sel ? PC : mem_addr.
- Register file: 2 combinational reads, 1 synchronous write.
  - Write: rc <= (c_sel ? alu_out : data_in) when write_reg_enable=1.
  - Read during a same-cycle write to the same register returns the old value (no bypass).
  - Register 0 is writable; it is not hard-wired to zero.
- ALU: combinational, DATA_W wide, result modulo 2^DATA_W.
  - ADD: uov = carry out; sov = carry into MSB xor carry out.
  - SUB: computed as A + ~B + 1. uov = borrow (A<B unsigned); sov = (A[msb]!=B[msb]) && (res[msb]!=A[msb]).
  - AND/OR: uov = sov = 0.
  - zero = (res==0); neg = res[msb].
- Flags: all four load together on flags_reg_enable=1; otherwise they hold.
  - Flags read by a branch reflect the last enabled flag load, not the current ALU output.
- Simultaneous ir_enable and pc_enable: both apply. The PC branch target uses the old IR.
- Reset asserted mid-operation clears everything immediately, regardless of the strobes.

Decomposition:
- k_and_s_pkg holds:
  - the 8-bit opcode localparams;
  - decoded_instruction_type (extended with I_BNOV and I_SUB);
  - the ALU operation encodings.
- Sub-module dp_reg_file: parametrised by DATA_W and NREGS, with async reset, 2 read ports and 1 write port.
- ALU, decoder and PC stay in data_path_param.

Test Plan:
- Reset: pulse rst_n low mid-cycle while pc_enable=1 -> PC=0, IR=0, flags=0, decoded_instruction=I_NOP, ram_addr=0 when addr_sel=1.
- PC wrap: PC=31, pc_enable=1, branch=0 -> PC=0. Then IR=0x0113 (BRANCH 19), branch=1 -> PC=19.
- ADD overflow: r1=0x7FFF, r2=0x0001, ADD r3=r1+r2 with writes/flags enabled -> r3=0x8000, neg=1, sov=1, uov=0, zero=0.
- SUB borrow: r1=0x0003, r2=0x0005, SUB -> res=0xFFFE, uov=1, sov=0, neg=1. Then r1=r2=0x0005 -> zero=1, uov=0.
- LOAD/STORE: IR=0x8125 (LOAD r1, addr 5), addr_sel=0 -> ram_addr=5; data_in=0xBEEF, c_sel=0 -> r1=0xBEEF. Then IR=0x8225 (STORE r1) -> data_out=0xBEEF.
- Flag hold and read/write hazard:
  - flags_reg_enable=0 during a result of 0 -> zero flag unchanged.
  - Write r2 and read r2 in the same cycle -> old value is returned.
  - Opcode 0x55 -> I_NOP.
